// File: rtl/uart_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_arb_pkg
// Description : Shared constants for the UART transmit arbiter: FSM state
//               encoding, requester limit, grant index width and the
//               round-robin pointer wrap helper.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_arb_pkg;

    // Arbiter FSM states
    localparam logic [1:0] S_ARB    = 2'd0;
    localparam logic [1:0] S_WAIT   = 2'd1;
    localparam logic [1:0] S_FIRE   = 2'd2;
    localparam logic [1:0] S_SETTLE = 2'd3;

    // Largest supported requester count and the index width it implies
    localparam int MAX_REQ = 8;
    localparam int GRANT_W = $clog2(MAX_REQ);

    // Successor of a requester index, wrapping from n-1 back to 0
    function automatic logic [GRANT_W-1:0] rr_next(input logic [GRANT_W-1:0] idx,
                                                   input int n);
        if (int'(idx) >= n - 1) begin
            return '0;
        end
        return idx + GRANT_W'(1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin picker. Returns the first set bit
//               of req searching upward from ptr, wrapping modulo N.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick
    import uart_arb_pkg::*;
#(
    parameter int N = 2
) (
    input  logic [N-1:0]       req,
    input  logic [GRANT_W-1:0] ptr,
    output logic               any,
    output logic [GRANT_W-1:0] idx
);

    // Walk the N positions starting at ptr; the first requesting one wins
    always_comb begin
        any = 1'b0;
        idx = '0;
        for (int k = 0; k < N; k++) begin
            for (int j = 0; j < N; j++) begin
                if (!any && req[j] && (j == (int'(ptr) + k) % N)) begin
                    any = 1'b1;
                    idx = GRANT_W'(j);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_arbiter
// Description : Shares one buart transmitter between N valid/ready byte
//               requesters. One byte per grant, round-robin order, honours
//               uart_busy and emits a single-cycle uart_wr strobe.
//               Optional macro UART_ARB_LOCK_EN: message lock, keeps a
//               multi-byte message (terminated by req_last) uninterleaved.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int N = 2
) (
    input  logic               clk,
    input  logic               resetq,
    input  logic [N-1:0]       req_valid,
    input  logic [8*N-1:0]     req_data,
    input  logic [N-1:0]       req_last,
    output logic [N-1:0]       req_ready,
    input  logic               uart_busy,
    output logic               uart_wr,
    output logic [7:0]         uart_data,
    output logic [GRANT_W-1:0] grant
);

    logic [1:0]         r_state;
    logic [GRANT_W-1:0] r_rr_ptr;
    logic [GRANT_W-1:0] r_grant;
    logic [N-1:0]       r_ready;
    logic               r_wr;
    logic [7:0]         r_data;

    logic [N-1:0]       w_req;
    logic [GRANT_W-1:0] w_ptr;
    logic               w_any;
    logic [GRANT_W-1:0] w_idx;
    logic [7:0]         w_sel_data;
    logic [N-1:0]       w_onehot;
    logic               w_ptr_adv;

`ifdef UART_ARB_LOCK_EN
    logic               r_lock;
    logic [GRANT_W-1:0] r_owner;
    logic [N-1:0]       w_owner_mask;
    logic               w_sel_last;

    // While a message is open only its owner may be granted
    always_comb begin
        w_owner_mask = '0;
        for (int i = 0; i < N; i++) begin
            w_owner_mask[i] = (r_owner == GRANT_W'(i));
        end
        w_req = r_lock ? (req_valid & w_owner_mask) : req_valid;
        w_ptr = r_lock ? r_owner : r_rr_ptr;
    end

    // End-of-message flag of the requester about to be granted
    always_comb begin
        w_sel_last = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (w_idx == GRANT_W'(i)) begin
                w_sel_last = req_last[i];
            end
        end
    end

    // Fairness only moves on once a whole message has gone out
    assign w_ptr_adv = w_sel_last;

    // Open the lock on a non-final byte, release it on the final one
    always_ff @(posedge clk) begin
        if (!resetq) begin
            r_lock  <= 1'b0;
            r_owner <= '0;
        end else if (r_state == S_ARB && w_any) begin
            if (w_sel_last) begin
                r_lock <= 1'b0;
            end else begin
                r_lock  <= 1'b1;
                r_owner <= w_idx;
            end
        end
    end
`else
    logic w_unused_last;

    // Every byte is arbitrated independently; end-of-message markers are ignored
    assign w_req         = req_valid;
    assign w_ptr         = r_rr_ptr;
    assign w_ptr_adv     = 1'b1;
    assign w_unused_last = ^req_last;
`endif

    rr_pick #(
        .N   (N)
    ) u_pick (
        .req (w_req),
        .ptr (w_ptr),
        .any (w_any),
        .idx (w_idx)
    );

    // Byte and accept pulse for the picked requester
    always_comb begin
        w_sel_data = 8'h00;
        w_onehot   = '0;
        for (int i = 0; i < N; i++) begin
            if (w_idx == GRANT_W'(i)) begin
                w_sel_data  = req_data[8*i +: 8];
                w_onehot[i] = 1'b1;
            end
        end
    end

    // Grant / wait-for-UART / strobe / settle sequencer; ready and wr are pulses
    always_ff @(posedge clk) begin
        if (!resetq) begin
            r_state  <= S_ARB;
            r_rr_ptr <= '0;
            r_grant  <= '0;
            r_ready  <= '0;
            r_wr     <= 1'b0;
            r_data   <= 8'h00;
        end else begin
            r_ready <= '0;
            r_wr    <= 1'b0;
            case (r_state)
                S_ARB: begin
                    if (w_any) begin
                        r_data  <= w_sel_data;
                        r_ready <= w_onehot;
                        r_grant <= w_idx;
                        if (w_ptr_adv) begin
                            r_rr_ptr <= rr_next(w_idx, N);
                        end
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (!uart_busy) begin
                        r_wr    <= 1'b1;
                        r_state <= S_FIRE;
                    end
                end
                // One idle cycle so buart can raise busy before we look again
                S_FIRE:   r_state <= S_SETTLE;
                S_SETTLE: r_state <= S_ARB;
                default:  r_state <= S_ARB;
            endcase
        end
    end

    assign req_ready = r_ready;
    assign uart_wr   = r_wr;
    assign uart_data = r_data;
    assign grant     = r_grant;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_arbiter
// Description : Self-checking bench for uart_tx_arbiter (N=3): directed
//               timing/reset/lock scenarios followed by randomized traffic
//               checked against a round-robin reference model.
//               Honours UART_ARB_LOCK_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

    localparam int N = 3;

    logic           clk = 1'b0;
    logic           resetq;
    logic [N-1:0]   req_valid;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ready;
    logic           uart_busy;
    logic           uart_wr;
    logic [7:0]     uart_data;
    logic [2:0]     grant;

    int total = 0;
    int bad   = 0;

    uart_tx_arbiter #(
        .N         (N)
    ) dut (
        .clk       (clk),
        .resetq    (resetq),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .uart_busy (uart_busy),
        .uart_wr   (uart_wr),
        .uart_data (uart_data),
        .grant     (grant)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        resetq    = 1'b0;
        req_valid = '0;
        req_last  = '1;
        uart_busy = 1'b0;
        tick;
        tick;
        resetq = 1'b1;
    endtask

    task automatic wait_ready(input int bound, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            tick;
            if (req_ready != '0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_wr(input int bound, output logic [7:0] b, output logic ok);
        ok = 1'b0;
        b  = 8'h00;
        for (int i = 0; i < bound; i++) begin
            tick;
            if (uart_wr) begin
                b  = uart_data;
                ok = 1'b1;
                break;
            end
        end
    endtask

    // random-phase storage
    logic [7:0] pd [N][8];
    logic       pl [N][8];
    int         cnt [N];
    int         pos [N];
    logic [7:0] exp_q [$];
    logic [7:0] got_q [$];

    initial begin
        logic       ok;
        logic [7:0] b;
        int         n;

        req_data = '0;

        // ---------------- reset state ----------------
        do_reset;
        chk("rst_ready", req_ready, 0);
        chk("rst_wr", uart_wr, 0);
        chk("rst_data", uart_data, 8'h00);
        chk("rst_grant", grant, 0);

        // ---------------- single byte timing ----------------
        req_data[7:0] = 8'h55;
        req_valid     = 3'b001;
        tick;
        chk("single_ready_c1", req_ready, 3'b001);
        chk("single_wr_c1", uart_wr, 0);
        chk("single_grant", grant, 0);
        req_valid = '0;
        tick;
        chk("single_wr_c2", uart_wr, 1);
        chk("single_data", uart_data, 8'h55);
        chk("single_ready_c2", req_ready, 0);
        n = 0;
        for (int i = 0; i < 12; i++) begin
            tick;
            if (uart_wr) n++;
        end
        chk("single_one_strobe", n, 0);

        // ---------------- alternation, both valid ----------------
        do_reset;
        req_data[7:0]  = 8'hA0;
        req_data[15:8] = 8'hB0;
        req_valid      = 3'b011;
        for (int k = 0; k < 6; k++) begin
            wait_ready(20, ok);
            chk("alt_ready_to", ok, 1);
            chk("alt_ready", req_ready, (k % 2 == 1) ? 3'b010 : 3'b001);
            wait_wr(20, b, ok);
            chk("alt_wr_to", ok, 1);
            chk("alt_data", b, (k % 2 == 1) ? 8'hB0 : 8'hA0);
        end
        req_valid = '0;
        tick; tick; tick; tick;

        // ---------------- busy stall ----------------
        do_reset;
        req_data[7:0] = 8'h33;
        req_valid     = 3'b001;
        tick;
        chk("busy_ready", req_ready, 3'b001);
        req_valid = '0;
        uart_busy = 1'b1;
        n = 0;
        for (int i = 0; i < 100; i++) begin
            tick;
            if (uart_wr) n++;
        end
        chk("busy_no_wr", n, 0);
        chk("busy_data_held", uart_data, 8'h33);
        uart_busy = 1'b0;
        tick;
        chk("busy_wr_after", uart_wr, 1);
        chk("busy_data", uart_data, 8'h33);
        tick;
        chk("busy_wr_single", uart_wr, 0);
        tick; tick;

        // ---------------- reset during S_WAIT ----------------
        do_reset;
        req_data[7:0] = 8'h01;
        req_valid     = 3'b001;
        wait_ready(10, ok);
        req_valid = '0;
        wait_wr(10, b, ok);
        chk("mrst_pre_wr", ok, 1);
        tick; tick;
        uart_busy      = 1'b1;
        req_data[7:0]  = 8'h03;
        req_data[15:8] = 8'h02;
        req_valid      = 3'b011;
        wait_ready(10, ok);
        chk("mrst_ptr1_grant", req_ready, 3'b010);
        tick;
        resetq = 1'b0;
        tick;
        chk("mrst_ready", req_ready, 0);
        chk("mrst_wr", uart_wr, 0);
        chk("mrst_data", uart_data, 8'h00);
        chk("mrst_grant", grant, 0);
        resetq    = 1'b1;
        uart_busy = 1'b0;
        tick;
        chk("mrst_first_ready", req_ready, 3'b001);
        chk("mrst_first_grant", grant, 0);
        req_valid = '0;
        tick;
        chk("mrst_wr_after", uart_wr, 1);
        chk("mrst_data_after", uart_data, 8'h03);
        tick; tick; tick;

        // ---------------- message lock scenario ----------------
        do_reset;
        begin
            int idx1;
            logic [7:0] m1 [3];
            logic [7:0] ex [4];
            m1[0] = 8'h10; m1[1] = 8'h11; m1[2] = 8'h12;
            idx1 = 0;
            got_q.delete();
            req_data[15:8] = m1[0];
            req_last       = 3'b000;
            req_valid      = 3'b010;
            for (int c = 0; c < 100 && got_q.size() < 4; c++) begin
                tick;
                if (uart_wr) got_q.push_back(uart_data);
                if (req_ready[0]) req_valid[0] = 1'b0;
                if (req_ready[1]) begin
                    idx1++;
                    if (idx1 == 1) begin
                        req_data[7:0] = 8'h77;
                        req_last[0]   = 1'b1;
                        req_valid[0]  = 1'b1;
                    end
                    if (idx1 < 3) begin
                        req_data[15:8] = m1[idx1];
                        req_last[1]    = (idx1 == 2);
                    end else begin
                        req_valid[1] = 1'b0;
                    end
                end
            end
`ifdef UART_ARB_LOCK_EN
            ex[0] = 8'h10; ex[1] = 8'h11; ex[2] = 8'h12; ex[3] = 8'h77;
`else
            ex[0] = 8'h10; ex[1] = 8'h77; ex[2] = 8'h11; ex[3] = 8'h12;
`endif
            chk("msg_count", got_q.size(), 4);
            for (int i = 0; i < 4; i++) begin
                chk("msg_byte", (i < got_q.size()) ? got_q[i] : 8'hxx, ex[i]);
            end
        end
        req_valid = '0;
        tick; tick; tick; tick;

        // ---------------- randomized traffic vs model ----------------
        do_reset;
        begin
            int   tot, delivered, m_ptr, m_owner, eg, g, c;
            bit   m_lock, found;
            logic prev_wr, bdrv;
            logic [N-1:0] vdrv;
            tot = 0; delivered = 0; m_ptr = 0; m_owner = 0; m_lock = 0;
            prev_wr = 1'b0;
            exp_q.delete();
            for (int i = 0; i < N; i++) begin
                cnt[i] = $urandom_range(3, 8);
                pos[i] = 0;
                tot += cnt[i];
                for (int j = 0; j < 8; j++) begin
                    pd[i][j] = 8'($urandom);
                    pl[i][j] = (j == cnt[i] - 1) ? 1'b1 : 1'($urandom % 2);
                end
            end
            for (int cyc = 0; cyc < 4000 && delivered < tot; cyc++) begin
                uart_busy = ($urandom % 3 == 0);
                vdrv = req_valid;
                bdrv = uart_busy;
                tick;
                if (req_ready != '0) begin
                    chk("rnd_onehot", $countones(req_ready), 1);
                    g = -1;
                    for (int i = 0; i < N; i++) if (req_ready[i]) g = i;
                    eg = -1;
                    if (m_lock) begin
                        eg = m_owner;
                    end else begin
                        found = 0;
                        for (int k = 0; k < N; k++) begin
                            c = (m_ptr + k) % N;
                            if (!found && vdrv[c]) begin
                                found = 1;
                                eg = c;
                            end
                        end
                    end
                    chk("rnd_grant", g, eg);
                    chk("rnd_grant_out", grant, eg);
                    if (g >= 0 && pos[g] < cnt[g]) begin
                        exp_q.push_back(pd[g][pos[g]]);
`ifdef UART_ARB_LOCK_EN
                        if (pl[g][pos[g]]) begin
                            m_lock = 0;
                            m_ptr  = (g + 1) % N;
                        end else begin
                            m_lock  = 1;
                            m_owner = g;
                        end
`else
                        m_ptr = (g + 1) % N;
`endif
                        pos[g]++;
                        req_valid[g] = 1'b0;
                    end
                end
                if (uart_wr) begin
                    chk("rnd_wr_busy", bdrv, 0);
                    chk("rnd_wr_double", prev_wr, 0);
                    chk("rnd_pending", exp_q.size(), 1);
                    if (exp_q.size() > 0) chk("rnd_data", uart_data, exp_q.pop_front());
                    delivered++;
                end
                prev_wr = uart_wr;
                for (int i = 0; i < N; i++) begin
                    if (!req_valid[i] && pos[i] < cnt[i] && ($urandom % 3 == 0)) begin
                        req_data[8*i +: 8] = pd[i][pos[i]];
                        req_last[i]        = pl[i][pos[i]];
                        req_valid[i]       = 1'b1;
                    end
                end
            end
            chk("rnd_all_delivered", delivered, tot);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
